time_set_ctrl: RTL
==================

# time_set_ctrl

Controller for the clock's time-setting mode. It takes the `switch_setting` level and the two setting push-buttons (next-field and increment), then sequences editing of the hours, minutes and seconds fields. It drives the six-digit display mux and the per-digit `flicker_mask`. When setting mode is left, it issues a one-cycle load strobe to the timekeeping counter. It sits between the raw front-panel inputs and the timekeeper/display path, and runs entirely in the 1 kHz domain.

## Interface
- `HOLD_CYC`, default 500: cycles a button must be held before auto-repeat starts (500 ms).
- `REPEAT_CYC`, default 125: cycles between auto-repeat increments (125 ms).
- `clk_1khz`  in  1  1 kHz system clock; all logic is on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `switch_setting`  in  1  level; 1 = setting mode requested.
- `btn_next`  in  1  raw level from `button_1`; selects the next field.
- `btn_inc`  in  1  raw level from `button_2`; increments the current field.
- `cur_hh`, `cur_mm`, `cur_ss`  in  8 each  live time from the timekeeper, packed BCD (tens in [7:4]).
- `set_hh`, `set_mm`, `set_ss`  out  8 each  edited time, packed BCD; valid while `setting_active` and on `load`.
- `load`  out  1  one-cycle strobe; the timekeeper loads `set_*` on this edge.
- `setting_active`  out  1  high whenever the FSM is not in IDLE.
- `flicker_mask`  out  [0:5]  bit 0 = hours tens … bit 5 = seconds units; a 1 blinks that digit.
- Reset values: `set_*` = 8'h00, `load` = 0, `setting_active` = 0, `flicker_mask` = 6'b000000, FSM = IDLE.

## Operation
- FSM states: IDLE, EDIT_HH, EDIT_MM, EDIT_SS, COMMIT.
- **IDLE:**
  - Each cycle, `set_*` <= `cur_*` (shadow copy).
  - On the first cycle `switch_setting` is seen high, go to EDIT_HH. The shadow then holds the time at entry.
- **EDIT_xx:**
  - A conditioned next-pulse moves HH→MM→SS→HH (wraps).
  - A conditioned inc-pulse increments the current field in BCD. Hours wrap 23→00; minutes and seconds wrap 59→00.
  - A field value above its limit, including invalid BCD, increments to 00.
- **Leaving edit:** `switch_setting` low in any EDIT state → COMMIT.
- **COMMIT:** `load` = 1 for exactly this cycle, then IDLE.
- **`flicker_mask`:**
  - EDIT_HH = 110000, EDIT_MM = 001100, EDIT_SS = 000011, otherwise 000000.
  - Forced to 000000 while `btn_inc` is held (conditioned level high), so the value stays visible during auto-repeat.
- **Button conditioning (per button):**
  - 2-flop synchronizer, then a registered delay; pulse = s2 & ~d.
  - Auto-repeat applies to inc only: while s2 stays high, a counter issues an extra pulse after `HOLD_CYC` cycles, then every `REPEAT_CYC` cycles. The counter clears when s2 falls.
- **Simultaneous events:**
  - Next and inc pulses in the same cycle: next wins, inc is dropped.
  - `switch_setting` falling in the same cycle as a pulse: the exit wins, the pulse is ignored, and the committed value is the pre-pulse value.
- **Reset:** `clr` mid-edit → IDLE with no `load`; edits are discarded.

## Timing
- **Button latency:** raw input high before edge N → s1 at N, s2 at N+1 → field register updated at edge N+2.
- **Auto-repeat, `btn_inc` held continuously from edge N:** increments at N+2, N+2+500, N+2+625, N+2+750, …
- **Entry:** `switch_setting` high before edge N → state EDIT_HH and `setting_active` = 1 after edge N. `switch_setting` is already synchronous to the panel scan and is not synchronized further.
- **Exit:** `switch_setting` low before edge N → COMMIT after N, `load` high for cycle N..N+1, IDLE after N+1.
- **Shadow copy:** `set_*` stays constant from the COMMIT cycle until one cycle after `load` falls.
- **Re-entry:** the FSM may re-enter EDIT_HH at N+2 at the earliest.

## Structure
- **Package `set_pkg`:**
  - state enum.
  - field limits HH_MAX = 8'h23, MS_MAX = 8'h59.
  - mask constants MASK_HH/MM/SS.
  - function `bcd_inc(val, max)` returning the wrapped packed-BCD increment.
- **Sub-module `btn_conditioner`** (parameters `HOLD_CYC`, `REPEAT_CYC`, `AUTOREPEAT`):
  - Outputs `pulse` and `level`.
  - Instantiated twice: next with `AUTOREPEAT` = 0, inc with `AUTOREPEAT` = 1.

## Test plan
- **Reset and entry:** `clr` for 3 cycles, `cur` = 12:34:56 → all outputs at reset values. Raise `switch_setting` → EDIT_HH, `flicker_mask` = 110000, `set_*` = 12:34:56.
- **Hours wrap:** in EDIT_HH with `set_hh` = 8'h22, two inc taps → 8'h23, then 8'h00. Minutes and seconds unchanged.
- **Field cycling and seconds wrap:** next ×2 → EDIT_SS, mask 000011. Seconds 8'h59 plus one inc → 8'h00. Next once more → EDIT_HH.
- **Auto-repeat:** hold `btn_inc` for 1000 cycles in EDIT_MM starting at 8'h00 → increments at offsets +2, +502, +627, +752, +877, final value 8'h05. `flicker_mask` = 000000 while held.
- **Commit:** edit to 07:08:09, drop `switch_setting` → exactly one `load` pulse with `set_*` = 07:08:09, then IDLE tracking `cur_*`.
- **Collisions:**
  - `clr` mid-edit → no `load`.
  - Next and inc rising on the same edge → field advances, value unchanged.
  - Invalid `cur_mm` = 8'h7A plus one inc → 8'h00.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared types and helpers for the time-setting controller: FSM states,
// BCD field limits, per-field blink masks and the wrapping BCD increment.
package set_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HH,
    EDIT_MM,
    EDIT_SS,
    COMMIT
  } state_e;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  localparam logic [0:5] MASK_HH   = 6'b110000;
  localparam logic [0:5] MASK_MM   = 6'b001100;
  localparam logic [0:5] MASK_SS   = 6'b000011;
  localparam logic [0:5] MASK_NONE = 6'b000000;

  // Anything at or past the limit, or not valid BCD, wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
    logic [7:0] res;
    if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val >= lim)) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Front-panel button conditioner: two-flop synchronizer, rising-edge pulse,
// and optional hold-to-repeat pulses while the button stays pressed.
module btn_conditioner #(
  parameter int HOLD_CYC   = 500,
  parameter int REPEAT_CYC = 125,
  parameter bit AUTOREPEAT = 1'b0
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic raw_i,
  output logic pulse,
  output logic level
);

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_CYC);
  localparam logic [CW-1:0] RELOAD_V = CW'(HOLD_CYC - REPEAT_CYC + 1);

  logic s1_q, s2_q, d_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Reloading below the hold threshold makes later repeats REPEAT_CYC apart.
  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q == HOLD_V) ? RELOAD_V : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      d_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      d_q   <= s2_q;
      cnt_q <= cnt_d;
    end
  end

  assign level = s2_q;
  assign pulse = (s2_q & ~d_q) | (AUTOREPEAT & s2_q & (cnt_q == HOLD_V));

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting mode controller: shadows the live time, lets the user edit
// hours/minutes/seconds with two buttons, and strobes load on exit.
module time_set_ctrl
  import set_pkg::*;
#(
  parameter int HOLD_CYC   = 500,
  parameter int REPEAT_CYC = 125
) (
  input  logic       clk_1khz,
  input  logic       clr,
  input  logic       switch_setting,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic       load,
  output logic       setting_active,
  output logic [0:5] flicker_mask
);

  state_e     state_q, state_d;
  logic [7:0] hh_q, mm_q, ss_q;
  logic [7:0] hh_d, mm_d, ss_d;
  logic       nextPulse, incPulse, incLevel;

  btn_conditioner #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .AUTOREPEAT(1'b0)
  ) u_next (
    .clk_i(clk_1khz),
    .clr_i(clr),
    .raw_i(btn_next),
    .pulse(nextPulse),
    .level()
  );

  btn_conditioner #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .AUTOREPEAT(1'b1)
  ) u_inc (
    .clk_i(clk_1khz),
    .clr_i(clr),
    .raw_i(btn_inc),
    .pulse(incPulse),
    .level(incLevel)
  );

  // Leaving edit takes priority over any button pulse; next beats inc.
  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    case (state_q)
      IDLE: begin
        hh_d = cur_hh;
        mm_d = cur_mm;
        ss_d = cur_ss;
        if (switch_setting) state_d = EDIT_HH;
      end
      EDIT_HH, EDIT_MM, EDIT_SS: begin
        if (!switch_setting) begin
          state_d = COMMIT;
        end else if (nextPulse) begin
          case (state_q)
            EDIT_HH: state_d = EDIT_MM;
            EDIT_MM: state_d = EDIT_SS;
            default: state_d = EDIT_HH;
          endcase
        end else if (incPulse) begin
          case (state_q)
            EDIT_HH: hh_d = bcd_inc(hh_q, HH_MAX);
            EDIT_MM: mm_d = bcd_inc(mm_q, MS_MAX);
            default: ss_d = bcd_inc(ss_q, MS_MAX);
          endcase
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (clr) begin
      state_q <= IDLE;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
    end
  end

  // Blinking is suppressed while inc is held so auto-repeat stays readable.
  always_comb begin
    flicker_mask = MASK_NONE;
    case (state_q)
      EDIT_HH: flicker_mask = MASK_HH;
      EDIT_MM: flicker_mask = MASK_MM;
      EDIT_SS: flicker_mask = MASK_SS;
      default: flicker_mask = MASK_NONE;
    endcase
    if (incLevel) flicker_mask = MASK_NONE;
  end

  assign set_hh         = hh_q;
  assign set_mm         = mm_q;
  assign set_ss         = ss_q;
  assign load           = (state_q == COMMIT);
  assign setting_active = (state_q != IDLE);

endmodule
